id_decode_stage: RTL
====================

# id_decode_stage

Instruction-decode pipeline stage of the Lab3 datapath, between instruction fetch and execute. Accepts fetched instruction/PC beats over a valid/ready handshake, decodes MIPS-subset fields and control bits, and holds them in a 2-entry skid buffer. Downstream, `out_imm16` feeds the 32-bit sign extender that drives ALU operand B.

## Interface
- `ADDR_W`, 32, PC width.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  discard all buffered beats (branch/jump redirect).
- `in_valid` / `in_ready`  in / out  1  upstream handshake.
- `in_instr`  in  32  instruction word.
- `in_pc`  in  ADDR_W  PC of `in_instr`.
- `out_valid` / `out_ready`  out / in  1  downstream handshake.
- `out_pc`  out  ADDR_W  PC of the head beat.
- `out_opcode`  out  6  instr[31:26].
- `out_rs`  out  5  instr[25:21].
- `out_rt`  out  5  instr[20:16].
- `out_rd`  out  5  instr[15:11].
- `out_shamt`  out  5  instr[10:6].
- `out_funct`  out  6  instr[5:0].
- `out_imm16`  out  16  instr[15:0], to the sign extender.
- `out_jaddr`  out  26  instr[25:0].
- `out_reg_write`, `out_mem_read`, `out_mem_write`, `out_branch`, `out_branch_ne`, `out_jump`, `out_alu_src_imm`, `out_reg_dst_rd`, `out_illegal`  out  1 each  decoded control bits.

## Operation
- Decode is combinational on `in_instr`. Decoded fields and controls are stored with the beat, so no decode happens on the output side.
- Opcode table (controls not listed are 0):
  - 0x00 R-type: reg_write, reg_dst_rd.
  - 0x02 J: jump.
  - 0x04 BEQ: branch.
  - 0x05 BNE: branch, branch_ne.
  - 0x08 ADDI and 0x0A SLTI: reg_write, alu_src_imm.
  - 0x23 LW: reg_write, mem_read, alu_src_imm.
  - 0x2B SW: mem_write, alu_src_imm.
- Any other opcode is undefined; handling is set by `ILLEGAL_TRAP_EN`.
- Storage is a main register (head, drives `out_*`) plus a skid register.
- FSM states EMPTY, ONE, FULL. Accept = `in_valid & in_ready`. Pop = `out_valid & out_ready`.
  - EMPTY: accept → ONE.
  - ONE: accept & !pop → FULL (beat goes to skid); accept & pop → ONE (new beat replaces head); pop only → EMPTY.
  - FULL: pop → ONE (skid moves to head); `in_valid` is ignored.
- `in_ready` = (state != FULL). `out_valid` = (state != EMPTY). Both decode from the state register only, with no combinational in→out path.
- `flush` has highest priority: next state is EMPTY. Any beat presented in the same cycle is dropped, even if `in_ready` is high.
- Reset: state EMPTY, so `in_ready`=1 and `out_valid`=0. All `out_*` data/control registers are 0. The skid register is cleared.
- Reset asserted mid-operation discards all beats immediately (asynchronous).
- Outputs hold stable while `out_valid & !out_ready`.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 beat/cycle while `out_ready` is held high.
- `in_ready` falls the cycle after a stall fills the skid. It rises the cycle after the first pop from FULL.
- No beat is lost or duplicated across any stall pattern. Order is preserved.

## Configuration
- `ID_DECODE_ILLEGAL_TRAP_EN` defined:
  - An undefined opcode sets `out_illegal`=1.
  - reg_write, mem_read, mem_write, branch, branch_ne and jump are forced to 0.
  - The beat still flows, so execute can trap on it.
- Not defined:
  - `out_illegal` is tied to 0.
  - An undefined opcode decodes as all-zero controls (NOP).
  - Field outputs are unchanged.

## Structure
- `id_decode_pkg` holds:
  - opcode localparams;
  - the `state_t` enum {EMPTY, ONE, FULL};
  - the packed `ctrl_t` struct of the control bits;
  - the packed `beat_t` struct (pc, fields, `ctrl_t`).
- Sub-module `instr_decoder`: purely combinational `in_instr` → `ctrl_t`. The macro is applied here.
- Top level contains the FSM and two `beat_t` registers.

## Test plan
- Reset, then 0x2008FFFF (ADDI) at pc 0x100 → next cycle: out_valid=1, rt=8, imm16=0xFFFF, reg_write=1, alu_src_imm=1, reg_dst_rd=0.
- 0x8FA90004 (LW) → rs=29, rt=9, imm16=0x0004, mem_read=1, reg_write=1. Then 0x00221820 → rs=1, rt=2, rd=3, funct=0x20, reg_dst_rd=1.
- Stream 5 beats with `out_ready` low for 3 cycles → in_ready drops after 2 accepted. Releasing yields all 5 pc values in order, none duplicated.
- FULL state with `flush`=1 and in_valid=1 → next cycle: out_valid=0, in_ready=1. Neither buffered beat nor the new beat ever appears at the output.
- 0xFC000000 (opcode 0x3F):
  - with the macro: out_illegal=1, all write/branch/jump controls 0;
  - without it: out_illegal=0, all controls 0.
- `reset_n` pulsed low while FULL → outputs 0 asynchronously, state EMPTY, in_ready=1.

Source files
------------

// File: rtl/id_decode_pkg.sv
// id_decode_pkg: shared types and constants for the ID decode stage.
//   - MIPS-subset opcode constants
//   - state_t : occupancy of the 2-entry skid buffer
//   - ctrl_t  : decoded control bits
//   - beat_t  : one stored beat (pc, instruction fields, ctrl_t)
// The PC field is PC_W wide. The top-level ADDR_W must not exceed PC_W.
package id_decode_pkg;

  localparam int PC_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic branch_ne;
    logic jump;
    logic alu_src_imm;
    logic reg_dst_rd;
    logic illegal;
  } ctrl_t;

  // imm16 and jaddr overlap the R-type fields, so only the fields are stored.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [5:0]      opcode;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [5:0]      funct;
    ctrl_t           ctrl;
  } beat_t;

endpackage

// File: rtl/id_decode_instr_decoder.sv
// instr_decoder: purely combinational opcode -> control-bit decode.
// Ports:
//   opcode_i  in  6   instr[31:26]
//   ctrl_o    out     decoded ctrl_t
// Build option: ID_DECODE_ILLEGAL_TRAP_EN
//   defined     - an undefined opcode sets ctrl_o.illegal.
//                 All other control bits stay 0.
//   not defined - an undefined opcode decodes as all-zero controls (NOP).
module instr_decoder
  import id_decode_pkg::*;
(
  input  logic [5:0] opcode_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (opcode_i)
      OP_RTYPE: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst_rd = 1'b1;
      end
      OP_J:   ctrl_o.jump = 1'b1;
      OP_BEQ: ctrl_o.branch = 1'b1;
      OP_BNE: begin
        ctrl_o.branch    = 1'b1;
        ctrl_o.branch_ne = 1'b1;
      end
      OP_ADDI, OP_SLTI: begin
        ctrl_o.reg_write   = 1'b1;
        ctrl_o.alu_src_imm = 1'b1;
      end
      OP_LW: begin
        ctrl_o.reg_write   = 1'b1;
        ctrl_o.mem_read    = 1'b1;
        ctrl_o.alu_src_imm = 1'b1;
      end
      OP_SW: begin
        ctrl_o.mem_write   = 1'b1;
        ctrl_o.alu_src_imm = 1'b1;
      end
      default: begin
`ifdef ID_DECODE_ILLEGAL_TRAP_EN
        // The beat still flows downstream so execute can raise the trap.
        ctrl_o.illegal = 1'b1;
`else
        ctrl_o = '0;
`endif
      end
    endcase
  end

endmodule

// File: rtl/id_decode_stage.sv
// id_decode_stage: instruction-decode pipeline stage with a 2-entry skid buffer.
//
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   flush                 drops every buffered beat and any beat offered in the
//                         same cycle
//   in_valid/in_ready     upstream handshake; in_instr and in_pc carry the beat
//   out_valid/out_ready   downstream handshake
//   out_pc, out_opcode .. out_jaddr      head-beat fields
//   out_reg_write .. out_illegal         head-beat control bits
//
// Build option: ID_DECODE_ILLEGAL_TRAP_EN (applied inside instr_decoder).
//
// state | meaning
// EMPTY | no beat buffered
// ONE   | head holds a beat and skid is free
// FULL  | head and skid both hold beats, so upstream is stalled
module id_decode_stage
  import id_decode_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [ADDR_W-1:0] in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [5:0]        out_opcode,
  output logic [4:0]        out_rs,
  output logic [4:0]        out_rt,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_shamt,
  output logic [5:0]        out_funct,
  output logic [15:0]       out_imm16,
  output logic [25:0]       out_jaddr,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_branch,
  output logic              out_branch_ne,
  output logic              out_jump,
  output logic              out_alu_src_imm,
  output logic              out_reg_dst_rd,
  output logic              out_illegal
);

  state_t state_q, state_d;
  beat_t  head_q, head_d;
  beat_t  skid_q, skid_d;
  beat_t  in_beat;
  ctrl_t  in_ctrl;
  logic   accept, pop;

  instr_decoder u_dec (
    .opcode_i (in_instr[31:26]),
    .ctrl_o   (in_ctrl)
  );

  always_comb begin
    in_beat        = '0;
    in_beat.pc     = PC_W'(in_pc);
    in_beat.opcode = in_instr[31:26];
    in_beat.rs     = in_instr[25:21];
    in_beat.rt     = in_instr[20:16];
    in_beat.rd     = in_instr[15:11];
    in_beat.shamt  = in_instr[10:6];
    in_beat.funct  = in_instr[5:0];
    in_beat.ctrl   = in_ctrl;
  end

  // Both handshake outputs decode from the state register alone.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            head_d  = in_beat;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_d = in_beat;
          end else if (accept) begin
            skid_d  = in_beat;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  assign out_pc          = head_q.pc[ADDR_W-1:0];
  assign out_opcode      = head_q.opcode;
  assign out_rs          = head_q.rs;
  assign out_rt          = head_q.rt;
  assign out_rd          = head_q.rd;
  assign out_shamt       = head_q.shamt;
  assign out_funct       = head_q.funct;
  assign out_imm16       = {head_q.rd, head_q.shamt, head_q.funct};
  assign out_jaddr       = {head_q.rs, head_q.rt, head_q.rd, head_q.shamt, head_q.funct};
  assign out_reg_write   = head_q.ctrl.reg_write;
  assign out_mem_read    = head_q.ctrl.mem_read;
  assign out_mem_write   = head_q.ctrl.mem_write;
  assign out_branch      = head_q.ctrl.branch;
  assign out_branch_ne   = head_q.ctrl.branch_ne;
  assign out_jump        = head_q.ctrl.jump;
  assign out_alu_src_imm = head_q.ctrl.alu_src_imm;
  assign out_reg_dst_rd  = head_q.ctrl.reg_dst_rd;
  assign out_illegal     = head_q.ctrl.illegal;

endmodule
